// File: rtl/noc_pkg.sv
// Types and constants shared by the mesh router blocks.
package noc_pkg;

  localparam int N_PORTS = 5;

  typedef enum logic [2:0] {
    P_LOCAL = 3'd0,
    P_NORTH = 3'd1,
    P_EAST  = 3'd2,
    P_SOUTH = 3'd3,
    P_WEST  = 3'd4
  } port_e;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Flit type field: bit 0 marks a head flit and bit 1 a tail flit.
  localparam int FLIT_HEAD_BIT = 0;
  localparam int FLIT_TAIL_BIT = 1;

  typedef logic [1:0] flit_type_t;

  localparam flit_type_t FLIT_BODY   = 2'b00;
  localparam flit_type_t FLIT_HEAD   = 2'b01;
  localparam flit_type_t FLIT_TAIL   = 2'b10;
  localparam flit_type_t FLIT_SINGLE = 2'b11;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first request bit found at or
// after ptr_i, wrapping from N-1 back to 0.
module rr_pick #(
  parameter  int N = 5,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic         valid_o,
  output logic [W-1:0] idx_o
);

  int unsigned pos;

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    pos     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      pos = (32'(ptr_i) + i) % N;
      if (!valid_o && req_i[pos]) begin
        valid_o = 1'b1;
        idx_o   = W'(pos);
      end
    end
  end

endmodule

// File: rtl/noc_output_arbiter.sv
// Wormhole output-port arbiter: grants one input per packet, round-robin,
// holds the grant until the owner's tail flit moves, and flags silent owners.
module noc_output_arbiter
  import noc_pkg::*;
#(
  parameter  int N_IN      = N_PORTS,
  parameter  int STALL_MAX = 64,
  localparam int SEL_W     = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IN-1:0]  req_i,
  input  logic [N_IN-1:0]  head_i,
  input  logic [N_IN-1:0]  tail_i,
  input  logic             out_ready_i,
  output logic [N_IN-1:0]  gnt_o,
  output logic [SEL_W-1:0] sel_o,
  output logic             xfer_o,
  output logic             busy_o,
  output logic             stall_err_o
);

  localparam int CNT_W = $clog2(STALL_MAX + 1);

  arb_state_e       state;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_valid;
  logic [N_IN-1:0]  candidates;
  logic [CNT_W-1:0] stall_cnt;
  logic             own_req;
  logic             own_tail;

  assign candidates = req_i & head_i;
  assign own_req    = req_i[sel_o];
  assign own_tail   = tail_i[sel_o];
  assign xfer_o     = (|(gnt_o & req_i)) & out_ready_i;

  rr_pick #(.N(N_IN)) u_pick (
    .req_i   (candidates),
    .ptr_i   (rr_ptr),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ARB_IDLE;
      gnt_o       <= '0;
      sel_o       <= '0;
      busy_o      <= 1'b0;
      rr_ptr      <= '0;
      stall_cnt   <= '0;
      stall_err_o <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          stall_cnt <= '0;
          if (pick_valid) begin
            gnt_o  <= N_IN'(1) << pick_idx;
            sel_o  <= pick_idx;
            busy_o <= 1'b1;
            state  <= ARB_LOCKED;
          end
        end
        ARB_LOCKED: begin
          // Any owner flit, even one held off by backpressure, proves liveness.
          if (own_req) begin
            stall_cnt <= '0;
          end else if (stall_cnt != CNT_W'(STALL_MAX)) begin
            stall_cnt <= stall_cnt + 1'b1;
            if (stall_cnt == CNT_W'(STALL_MAX - 1)) stall_err_o <= 1'b1;
          end
          if (own_req && out_ready_i && own_tail) begin
            gnt_o  <= '0;
            busy_o <= 1'b0;
            rr_ptr <= (sel_o == SEL_W'(N_IN - 1)) ? '0 : sel_o + 1'b1;
            state  <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Directed bench for noc_output_arbiter: reset, fairness, wormhole lock,
// backpressure, stall watchdog, pointer wrap and asynchronous reset.
module tb_noc_output_arbiter;

  logic       clk;
  logic       rst_n;
  logic [4:0] req_i;
  logic [4:0] head_i;
  logic [4:0] tail_i;
  logic       out_ready_i;
  logic [4:0] gnt_o;
  logic [2:0] sel_o;
  logic       xfer_o;
  logic       busy_o;
  logic       stall_err_o;

  int checks = 0;
  int errors = 0;

  noc_output_arbiter #(.N_IN(5), .STALL_MAX(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_i),
    .head_i      (head_i),
    .tail_i      (tail_i),
    .out_ready_i (out_ready_i),
    .gnt_o       (gnt_o),
    .sel_o       (sel_o),
    .xfer_o      (xfer_o),
    .busy_o      (busy_o),
    .stall_err_o (stall_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [4:0] r, input logic [4:0] h, input logic [4:0] t,
                        input logic rdy);
    req_i = r; head_i = h; tail_i = t; out_ready_i = rdy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in(5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom));
      step();
    end
    checks++; if (gnt_o !== 5'b0) begin errors++; $display("FAIL reset_gnt got %b want %b", gnt_o, 5'b0); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
    checks++; if (stall_err_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall_err_o); end
    checks++; if (sel_o !== 3'd0) begin errors++; $display("FAIL reset_sel got %0d want 0", sel_o); end
    set_in(5'b0, 5'b0, 5'b0, 1'b1);
    rst_n = 1'b1;
  endtask

  task automatic test_fairness();
    int order [6] = '{0, 2, 4, 0, 2, 4};
    logic [4:0] exp;
    set_in(5'b10101, 5'b10101, 5'b10101, 1'b1);
    for (int g = 0; g < 6; g++) begin
      step();
      exp = 5'b00001 << order[g];
      checks++; if (gnt_o !== exp) begin errors++; $display("FAIL fair_gnt[%0d] got %b want %b", g, gnt_o, exp); end
      checks++; if (sel_o !== 3'(order[g])) begin errors++; $display("FAIL fair_sel[%0d] got %0d want %0d", g, sel_o, order[g]); end
      checks++; if (xfer_o !== 1'b1) begin errors++; $display("FAIL fair_xfer[%0d] got %b want 1", g, xfer_o); end
      step();
      checks++; if (gnt_o !== 5'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL fair_idle[%0d] got gnt %b busy %b want 00000 0", g, gnt_o, busy_o); end
    end
    set_in(5'b0, 5'b0, 5'b0, 1'b1);
  endtask

  task automatic test_wormhole();
    logic [4:0] hv [4] = '{5'b01010, 5'b01010, 5'b01000, 5'b01000};
    logic [4:0] tv [4] = '{5'b00000, 5'b00000, 5'b00000, 5'b00010};
    set_in(5'b00010, 5'b00010, 5'b00000, 1'b1);
    for (int f = 0; f < 4; f++) begin
      step();
      checks++; if (gnt_o !== 5'b00010) begin errors++; $display("FAIL worm_gnt[%0d] got %b want 00010", f, gnt_o); end
      set_in(5'b01010, hv[f], tv[f], 1'b1);
      #1;
      checks++; if (xfer_o !== 1'b1) begin errors++; $display("FAIL worm_xfer[%0d] got %b want 1", f, xfer_o); end
    end
    step();
    checks++; if (gnt_o !== 5'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL worm_release got gnt %b busy %b want 00000 0", gnt_o, busy_o); end
    set_in(5'b01000, 5'b01000, 5'b01000, 1'b1);
    step();
    checks++; if (gnt_o !== 5'b01000 || sel_o !== 3'd3) begin errors++; $display("FAIL worm_next got gnt %b sel %0d want 01000 3", gnt_o, sel_o); end
    step();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL worm_next_release got busy %b want 0", busy_o); end
    set_in(5'b0, 5'b0, 5'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    int bad = 0;
    set_in(5'b00100, 5'b00100, 5'b00000, 1'b0);
    step();
    checks++; if (gnt_o !== 5'b00100) begin errors++; $display("FAIL bp_grant got %b want 00100", gnt_o); end
    set_in(5'b00100, 5'b00000, 5'b00000, 1'b0);
    for (int c = 0; c < 100; c++) begin
      #1;
      checks++;
      if (xfer_o !== 1'b0 || gnt_o !== 5'b00100 || stall_err_o !== 1'b0) begin
        errors++;
        if (bad++ < 3) $display("FAIL bp_cycle[%0d] got xfer %b gnt %b stall %b want 0 00100 0", c, xfer_o, gnt_o, stall_err_o);
      end
      step();
    end
  endtask

  task automatic test_stall();
    set_in(5'b00000, 5'b00000, 5'b00000, 1'b1);
    for (int k = 1; k <= 64; k++) begin
      step();
      if (k == 63) begin
        checks++; if (stall_err_o !== 1'b0) begin errors++; $display("FAIL stall_early got %b want 0", stall_err_o); end
      end
    end
    checks++; if (stall_err_o !== 1'b1) begin errors++; $display("FAIL stall_set got %b want 1", stall_err_o); end
    checks++; if (gnt_o !== 5'b00100) begin errors++; $display("FAIL stall_lock got %b want 00100", gnt_o); end
    set_in(5'b00100, 5'b00000, 5'b00100, 1'b1);
    #1;
    checks++; if (xfer_o !== 1'b1) begin errors++; $display("FAIL stall_tail_xfer got %b want 1", xfer_o); end
    step();
    checks++; if (busy_o !== 1'b0 || stall_err_o !== 1'b1) begin errors++; $display("FAIL stall_sticky got busy %b stall %b want 0 1", busy_o, stall_err_o); end
    set_in(5'b0, 5'b0, 5'b0, 1'b1);
  endtask

  task automatic test_wrap_reset();
    set_in(5'b10000, 5'b10000, 5'b10000, 1'b1);
    step();
    checks++; if (gnt_o !== 5'b10000 || sel_o !== 3'd4) begin errors++; $display("FAIL wrap_owner got gnt %b sel %0d want 10000 4", gnt_o, sel_o); end
    step();
    set_in(5'b00011, 5'b00011, 5'b00000, 1'b1);
    step();
    checks++; if (gnt_o !== 5'b00001 || sel_o !== 3'd0) begin errors++; $display("FAIL wrap_pick got gnt %b sel %0d want 00001 0", gnt_o, sel_o); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (gnt_o !== 5'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL async_rst got gnt %b busy %b want 00000 0", gnt_o, busy_o); end
    checks++; if (sel_o !== 3'd0 || stall_err_o !== 1'b0) begin errors++; $display("FAIL async_rst_state got sel %0d stall %b want 0 0", sel_o, stall_err_o); end
    step();
    set_in(5'b0, 5'b0, 5'b0, 1'b1);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    set_in(5'b0, 5'b0, 5'b0, 1'b1);
    rst_n = 1'b1;
    #2;
    test_reset();
    test_fairness();
    test_wormhole();
    test_backpressure();
    test_stall();
    test_wrap_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
